// File: rtl/divider.sv
// Signed 32-bit restoring divider: one quotient bit per clock, then a sign-fix cycle.
// Result packs {remainder, quotient}; a zero divisor finishes in one cycle with a flag.
module divider (
  input  logic        clk,
  input  logic        clr,
  input  logic        start,
  input  logic [31:0] A,
  input  logic [31:0] B,
  output logic [63:0] Result,
  output logic        busy,
  output logic        done,
  output logic        div_by_zero,
  output logic [1:0]  o_dbg_state
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    FIX  = 2'd2,
    DONE = 2'd3
  } state_t;

  state_t      r_state;
  state_t      w_next_state;

  logic        r_sign_a;
  logic        r_sign_b;
  logic [31:0] r_mag_b;
  logic [31:0] r_rem;
  logic [31:0] r_quo;
  logic [4:0]  r_cnt;
  logic [63:0] r_result;
  logic        r_dbz;

  logic        w_accept;
  logic        w_b_zero;
  logic [31:0] w_mag_a;
  logic [31:0] w_mag_b;
  logic [32:0] w_shift;
  logic [32:0] w_trial;
  logic [31:0] w_quo_fix;
  logic [31:0] w_rem_fix;

  assign w_accept = (r_state == IDLE) && start;
  assign w_b_zero = (B == 32'd0);
  assign w_mag_a  = A[31] ? (~A + 32'd1) : A;
  assign w_mag_b  = B[31] ? (~B + 32'd1) : B;

  // The remainder stays below |B| <= 2^31, so the shifted value fits in 32 bits;
  // the extra bit only carries the borrow of the trial subtraction.
  assign w_shift  = {r_rem, r_quo[31]};
  assign w_trial  = w_shift - {1'b0, r_mag_b};

  assign w_quo_fix = (r_sign_a ^ r_sign_b) ? (~r_quo + 32'd1) : r_quo;
  assign w_rem_fix = r_sign_a ? (~r_rem + 32'd1) : r_rem;

  always_ff @(posedge clk or negedge clr) begin
    if (!clr) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_next_state;
    end
  end

  always_comb begin
    w_next_state = r_state;
    busy         = 1'b0;
    done         = 1'b0;
    case (r_state)
      IDLE: begin
        if (start) begin
          w_next_state = w_b_zero ? DONE : CALC;
        end
      end
      CALC: begin
        busy = 1'b1;
        if (r_cnt == 5'd0) begin
          w_next_state = FIX;
        end
      end
      FIX: begin
        busy         = 1'b1;
        w_next_state = DONE;
      end
      DONE: begin
        done         = 1'b1;
        w_next_state = IDLE;
      end
      default: begin
        w_next_state = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge clr) begin
    if (!clr) begin
      r_sign_a <= 1'b0;
      r_sign_b <= 1'b0;
      r_mag_b  <= 32'd0;
      r_rem    <= 32'd0;
      r_quo    <= 32'd0;
      r_cnt    <= 5'd0;
      r_result <= 64'd0;
      r_dbz    <= 1'b0;
    end else begin
      case (r_state)
        IDLE: begin
          if (w_accept) begin
            r_sign_a <= A[31];
            r_sign_b <= B[31];
            r_mag_b  <= w_mag_b;
            r_rem    <= 32'd0;
            r_quo    <= w_mag_a;
            r_cnt    <= 5'd31;
            r_dbz    <= w_b_zero;
            if (w_b_zero) begin
              r_result <= {A, 32'hFFFF_FFFF};
            end
          end
        end
        CALC: begin
          // Borrow set means the trial went negative: keep the shifted remainder.
          r_rem <= w_trial[32] ? w_shift[31:0] : w_trial[31:0];
          r_quo <= {r_quo[30:0], ~w_trial[32]};
          if (r_cnt != 5'd0) begin
            r_cnt <= r_cnt - 5'd1;
          end
        end
        FIX: begin
          r_result <= {w_rem_fix, w_quo_fix};
        end
        default: begin
        end
      endcase
    end
  end

  assign Result      = r_result;
  assign div_by_zero = r_dbz;
  assign o_dbg_state = r_state;

endmodule

// File: tb/tb_divider.sv
// Directed bench for divider: hand-computed quotient/remainder vectors, latency,
// busy/done timing, divide-by-zero, ignored starts and mid-operation reset.
module tb_divider;

  logic        clk;
  logic        clr;
  logic        start;
  logic [31:0] A;
  logic [31:0] B;
  logic [63:0] Result;
  logic        busy;
  logic        done;
  logic        div_by_zero;
  logic [1:0]  o_dbg_state;

  int          n_checks;
  int          n_pass;
  logic [63:0] exp_q[$];
  logic [63:0] last_res;

  divider dut (
    .clk         (clk),
    .clr         (clr),
    .start       (start),
    .A           (A),
    .B           (B),
    .Result      (Result),
    .busy        (busy),
    .done        (done),
    .div_by_zero (div_by_zero),
    .o_dbg_state (o_dbg_state)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs === exp) begin
      n_pass++;
    end else begin
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  // driver: present operands for exactly one rising edge (edge N)
  task automatic start_op(input logic [31:0] a, input logic [31:0] b);
    @(negedge clk);
    A     = a;
    B     = b;
    start = 1'b1;
    @(posedge clk);
    @(negedge clk);
    start = 1'b0;
  endtask

  // full operation with scoreboard; returns at the negedge where done is high
  task automatic run_div(input string tag, input logic [31:0] a, input logic [31:0] b,
                         input logic [63:0] exp_res, input logic exp_dbz, input int exp_lat);
    int k;
    int busy_cnt;
    exp_q.push_back(exp_res);
    start_op(a, b);
    check($sformatf("%s_dbz_at_accept", tag), {63'd0, div_by_zero}, {63'd0, exp_dbz});
    k        = 0;
    busy_cnt = 0;
    while (done !== 1'b1 && k < 100) begin
      if (busy === 1'b1) busy_cnt++;
      if (k == 16) check($sformatf("%s_hold_in_calc", tag), Result, last_res);
      @(negedge clk);
      k++;
    end
    check($sformatf("%s_latency", tag), 64'(k), 64'(exp_lat));
    check($sformatf("%s_busy_cycles", tag), 64'(busy_cnt), 64'(exp_lat));
    check($sformatf("%s_busy_with_done", tag), {63'd0, busy}, 64'd0);
    check($sformatf("%s_result", tag), Result, exp_q.pop_front());
    check($sformatf("%s_dbz", tag), {63'd0, div_by_zero}, {63'd0, exp_dbz});
    last_res = exp_res;
  endtask

  initial begin
    int k;
    int done_seen;
    n_checks = 0;
    n_pass   = 0;
    last_res = 64'd0;
    clr      = 1'b1;
    start    = 1'b0;
    A        = 32'd0;
    B        = 32'd0;

    // asynchronous reset, checked before any clock edge
    #3 clr = 1'b0;
    #1;
    check("rst_result", Result, 64'd0);
    check("rst_busy", {63'd0, busy}, 64'd0);
    check("rst_done", {63'd0, done}, 64'd0);
    check("rst_dbz", {63'd0, div_by_zero}, 64'd0);
    check("rst_state", {62'd0, o_dbg_state}, 64'd0);
    repeat (2) @(negedge clk);
    clr = 1'b1;

    run_div("p100_7", 32'd100, 32'd7, 64'h00000002_0000000E, 1'b0, 33);
    @(negedge clk);
    check("done_one_cycle", {63'd0, done}, 64'd0);
    run_div("m100_7", 32'hFFFFFF9C, 32'd7, 64'hFFFFFFFE_FFFFFFF2, 1'b0, 33);
    run_div("p100_m7", 32'd100, 32'hFFFFFFF9, 64'h00000002_FFFFFFF2, 1'b0, 33);
    run_div("m100_m7", 32'hFFFFFF9C, 32'hFFFFFFF9, 64'hFFFFFFFE_0000000E, 1'b0, 33);
    run_div("m7_2", 32'hFFFFFFF9, 32'd2, 64'hFFFFFFFF_FFFFFFFD, 1'b0, 33);
    run_div("small_big", 32'd7, 32'd100, 64'h00000007_00000000, 1'b0, 33);
    run_div("max_1", 32'h7FFFFFFF, 32'd1, 64'h00000000_7FFFFFFF, 1'b0, 33);
    run_div("min_min", 32'h80000000, 32'h80000000, 64'h00000000_00000001, 1'b0, 33);
    run_div("overflow", 32'h80000000, 32'hFFFFFFFF, 64'h00000000_80000000, 1'b0, 33);
    run_div("zero_3", 32'd0, 32'd3, 64'd0, 1'b0, 33);

    // divide by zero, then a valid divide must clear the flag at its accept
    run_div("div0", 32'd5, 32'd0, 64'h00000005_FFFFFFFF, 1'b1, 0);
    run_div("after_div0", 32'd100, 32'd7, 64'h00000002_0000000E, 1'b0, 33);

    // start held through the done cycle: only the IDLE edge may accept it
    A     = 32'd20;
    B     = 32'd3;
    start = 1'b1;
    @(negedge clk);
    check("b2b_not_accepted_in_done", {63'd0, busy}, 64'd0);
    @(posedge clk);
    @(negedge clk);
    start = 1'b0;
    k = 0;
    while (done !== 1'b1 && k < 100) begin
      @(negedge clk);
      k++;
    end
    check("b2b_latency", 64'(k), 64'd33);
    check("b2b_result", Result, 64'h00000002_00000006);
    last_res = 64'h00000002_00000006;

    // start re-pulsed with other operands during CALC is ignored
    exp_q.push_back(64'h00000002_0000000E);
    start_op(32'd100, 32'd7);
    repeat (5) @(negedge clk);
    A     = 32'd1;
    B     = 32'd1;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    k = 0;
    while (done !== 1'b1 && k < 100) begin
      @(negedge clk);
      k++;
    end
    check("repulse_latency", 64'(k), 64'd27);
    check("repulse_result", Result, exp_q.pop_front());
    last_res = 64'h00000002_0000000E;

    // reset at the 10th CALC edge aborts with no done pulse afterwards
    start_op(32'hFFFFFF9C, 32'd7);
    repeat (9) @(posedge clk);
    #2 clr = 1'b0;
    #1;
    check("midrst_result", Result, 64'd0);
    check("midrst_busy", {63'd0, busy}, 64'd0);
    check("midrst_done", {63'd0, done}, 64'd0);
    check("midrst_dbz", {63'd0, div_by_zero}, 64'd0);
    check("midrst_state", {62'd0, o_dbg_state}, 64'd0);
    @(negedge clk);
    clr = 1'b1;
    last_res  = 64'd0;
    done_seen = 0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (done === 1'b1 || busy === 1'b1) done_seen++;
    end
    check("midrst_no_done", 64'(done_seen), 64'd0);
    run_div("post_rst", 32'd100, 32'd7, 64'h00000002_0000000E, 1'b0, 33);

    repeat (3) @(negedge clk);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/divider.md
DIVIDER -- requirements
Module: divider

Interface
REQ-001 SHALL have port clk, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-002 SHALL have port clr, input, 1 bit: reset, asynchronous and active-low.
REQ-003 SHALL have port start, input, 1 bit: request a divide; sampled on the rising edge of clk.
REQ-004 SHALL have port A, input, 32 bits: dividend, signed two's complement.
REQ-005 SHALL have port B, input, 32 bits: divisor, signed two's complement.
REQ-006 SHALL have port Result, output, 64 bits: Result[63:32] = remainder (HI), Result[31:0] = quotient (LO), registered.
REQ-007 SHALL have port busy, output, 1 bit: high while an operation is in progress.
REQ-008 SHALL have port done, output, 1 bit: single-cycle completion pulse.
REQ-009 SHALL have port div_by_zero, output, 1 bit: high with done when B was 0; held until the next accepted start.
REQ-010 SHALL have no parameters; all widths are fixed as listed.

Function
REQ-011 SHALL implement FSM states IDLE, CALC, FIX, DONE.
REQ-012 Accept: in IDLE with start=1 at edge N, SHALL latch A and B, record both sign bits, load the magnitudes |A| and |B|, clear div_by_zero, and enter CALC.
REQ-013 SHALL ignore start in CALC, FIX and DONE; latched operands SHALL NOT change until the next accept.
REQ-014 CALC: SHALL perform one restoring step per edge (shift the remainder:quotient pair left 1, trial-subtract |B|, keep the difference and set the quotient bit if it is non-negative, else restore) using a 33-bit trial difference.
REQ-015 CALC: SHALL use a 5-bit down-counter loaded to 31 on accept; after the step at counter 0 (edge N+32), SHALL enter FIX.
REQ-016 FIX (edge N+33): SHALL negate the quotient if the recorded signs differ, negate the remainder if the dividend was negative, write Result, and enter DONE.
REQ-017 DONE: SHALL drive done=1 for exactly one cycle (the cycle after edge N+33) with busy=0, then return to IDLE at the next edge.
REQ-018 SHALL drive busy=1 from the edge after accept through the edge that enters DONE, and busy=0 in IDLE and DONE.
REQ-019 Rounding: the quotient SHALL truncate toward zero; the remainder SHALL carry the dividend's sign, or be 0; Q*B+R SHALL equal A for all B≠0.
REQ-020 Divide by zero: with B=0 at accept, SHALL skip CALC/FIX, write Result={A, 32'hFFFFFFFF}, set div_by_zero=1, and enter DONE at edge N (done=1 the following cycle).
REQ-021 Overflow: A=0x80000000, B=0xFFFFFFFF SHALL give quotient 0x80000000 and remainder 0, with no flag.
REQ-022 Result SHALL hold its value from the FIX or div-by-zero write until the next completed operation; it SHALL NOT change during CALC.
REQ-023 Back-to-back: a start asserted in the cycle that done=1 SHALL be ignored; the earliest accept is the first edge in IDLE.

Reset
REQ-024 clr=0 SHALL immediately, with no clock edge, force state=IDLE, Result=0, busy=0, done=0, div_by_zero=0, counter=0, and clear all internal operand registers.
REQ-025 Reset asserted mid-operation SHALL abort it; no done pulse SHALL follow reset deassertion.
REQ-026 After clr rises, the first start SHALL be accepted on the first rising edge with start=1.

Verification
REQ-027 A=100, B=7, start at edge N -> busy=1 for edges N+1..N+33; done=1 after edge N+33; Result=0x00000002_0000000E; div_by_zero=0.
REQ-028 A=-100 (0xFFFFFF9C), B=7 -> Result=0xFFFFFFFE_FFFFFFF2; A=100, B=-7 -> Result=0x00000002_FFFFFFF2.
REQ-029 A=5, B=0 -> done=1 one cycle after accept, Result=0x00000005_FFFFFFFF, div_by_zero=1; the next valid divide clears div_by_zero at its accept.
REQ-030 A=0x80000000, B=0xFFFFFFFF -> Result=0x00000000_80000000; A=0, B=3 -> Result=0.
REQ-031 Start re-pulsed with new A/B during CALC -> ignored; the original operands' result appears on schedule.
REQ-032 clr pulsed low at the 10th CALC edge -> all outputs 0 immediately, no done pulse; a subsequent 100/7 completes correctly.
